// File: rtl/ssb_demod_pipe.sv
// rtl/ssb_demod_pipe.sv - three-stage I/Q SSB/AM demodulator with gain, saturation and click-free mute
module ssb_demod_pipe #(
  parameter int WIDTH        = 12,
  parameter int MUTE_SAMPLES = 16,
  parameter int MAX_GAIN     = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       mode,
  input  logic [1:0]       gain_shift,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_clip
);

  localparam int RW = WIDTH + 2;  // stage-1/2 working width, holds a+b and AM sum
  localparam int EW = WIDTH + 5;  // stage-3 width, holds r shifted left by up to 3
  localparam int CW = (MUTE_SAMPLES > 0) ? $clog2(MUTE_SAMPLES + 1) : 1;

  localparam logic [1:0] MODE_LSB = 2'b00;
  localparam logic [1:0] MODE_USB = 2'b01;
  localparam logic [1:0] MODE_AM  = 2'b10;

  localparam logic signed [EW-1:0] SAT_HI = EW'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [EW-1:0] SAT_LO = EW'(-(2 ** (WIDTH - 1)));

  // stage 1: sign-extend, then add/sub for SSB or take magnitudes for AM
  logic signed [RW-1:0] w_a_ext, w_b_ext, w_a_abs, w_b_abs;
  logic signed [RW-1:0] w_s1_p, w_s1_q;

  assign w_a_ext = {{2{in_a[WIDTH-1]}}, in_a};
  assign w_b_ext = {{2{in_b[WIDTH-1]}}, in_b};
  assign w_a_abs = in_a[WIDTH-1] ? -w_a_ext : w_a_ext;
  assign w_b_abs = in_b[WIDTH-1] ? -w_b_ext : w_b_ext;

  // select stage-1 operands by mode; mute leaves both at zero
  always_comb begin
    w_s1_p = '0;
    w_s1_q = '0;
    case (mode)
      MODE_LSB: w_s1_p = w_a_ext - w_b_ext;
      MODE_USB: w_s1_p = w_a_ext + w_b_ext;
      MODE_AM: begin
        w_s1_p = w_a_abs;
        w_s1_q = w_b_abs;
      end
      default: ;
    endcase
  end

  logic                 r_s1_valid;
  logic [1:0]           r_s1_mode, r_s1_gain;
  logic signed [RW-1:0] r_s1_p, r_s1_q;

  // stage-1 register; mode and gain are captured only with a valid sample
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= '0;
      r_s1_gain  <= '0;
      r_s1_p     <= '0;
      r_s1_q     <= '0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_mode <= mode;
        r_s1_gain <= gain_shift;
        r_s1_p    <= w_s1_p;
        r_s1_q    <= w_s1_q;
      end
    end
  end

  // stage 2: AM envelope approximation max + min/2, SSB/mute pass through
  logic signed [RW-1:0] w_max, w_min, w_s2_r;

  assign w_max  = (r_s1_p > r_s1_q) ? r_s1_p : r_s1_q;
  assign w_min  = (r_s1_p > r_s1_q) ? r_s1_q : r_s1_p;
  assign w_s2_r = (r_s1_mode == MODE_AM) ? (w_max + (w_min >>> 1)) : r_s1_p;

  logic                 r_s2_valid;
  logic [1:0]           r_s2_mode, r_s2_gain;
  logic signed [RW-1:0] r_s2_r;

  // stage-2 register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_s2_valid <= 1'b0;
      r_s2_mode  <= '0;
      r_s2_gain  <= '0;
      r_s2_r     <= '0;
    end else begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_mode <= r_s1_mode;
        r_s2_gain <= r_s1_gain;
        r_s2_r    <= w_s2_r;
      end
    end
  end

  // stage 3: gain, halve with floor rounding, saturate to WIDTH bits
  logic [1:0]           w_g;
  logic signed [EW-1:0] w_wide, w_shl, w_v;
  logic [WIDTH-1:0]     w_sat;
  logic                 w_clip;

  assign w_g    = (int'(r_s2_gain) > MAX_GAIN) ? 2'(MAX_GAIN) : r_s2_gain;
  assign w_wide = {{(EW - RW){r_s2_r[RW-1]}}, r_s2_r};
  assign w_shl  = w_wide <<< w_g;
  assign w_v    = w_shl >>> 1;

  // clamp to the signed output range and flag when the limit bites
  always_comb begin
    w_sat  = w_v[WIDTH-1:0];
    w_clip = 1'b0;
    if (w_v > SAT_HI) begin
      w_sat  = SAT_HI[WIDTH-1:0];
      w_clip = 1'b1;
    end else if (w_v < SAT_LO) begin
      w_sat  = SAT_LO[WIDTH-1:0];
      w_clip = 1'b1;
    end
  end

  // mode-change mute: the triggering sample is the first of the muted run
  logic          r_first;
  logic [1:0]    r_last_mode;
  logic [CW-1:0] r_mute_cnt;
  logic          w_change, w_load, w_mute;

  assign w_change = !r_first && (r_s2_mode != r_last_mode);
  assign w_load   = (MUTE_SAMPLES > 0) && w_change;
  assign w_mute   = w_load || (r_mute_cnt != '0);

  logic             r_out_valid, r_out_clip;
  logic [WIDTH-1:0] r_out_data;

  // output register and mute bookkeeping; data/clip hold between valids
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_clip  <= 1'b0;
      r_first     <= 1'b1;
      r_last_mode <= '0;
      r_mute_cnt  <= '0;
    end else begin
      r_out_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_out_data  <= w_mute ? '0 : w_sat;
        r_out_clip  <= w_mute ? 1'b0 : w_clip;
        r_last_mode <= r_s2_mode;
        r_first     <= 1'b0;
        if (w_load) begin
          r_mute_cnt <= CW'(MUTE_SAMPLES - 1);
        end else if (r_mute_cnt != '0) begin
          r_mute_cnt <= r_mute_cnt - 1'b1;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_clip  = r_out_clip;

endmodule

// File: doc/ssb_demod_pipe.md
Name: ssb_demod_pipe

Overview:
- Parametrised, pipelined successor to the combinational 12-bit I/Q add/sub SSB combiner.
- Sits after the Hilbert/phase-shift path and before the audio decimator.
- Takes the phase-shifted I/Q pair with a per-sample valid strobe and produces a demodulated audio sample.
- Modes: USB, LSB, AM (envelope approximation) and mute. Adds programmable gain, output saturation, and click-free muting on mode change.

Parameters:
- WIDTH, 12, input and output sample width (two's complement).
- MUTE_SAMPLES, 16, number of valid output samples forced to zero after a mode change; 0 disables.
- MAX_GAIN, 3, largest accepted gain_shift value; larger values clamp to MAX_GAIN.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  qualifies in_a/in_b/mode/gain_shift for one cycle.
- in_a  in  WIDTH  I-path sample, signed.
- in_b  in  WIDTH  Q-path (phase-shifted) sample, signed.
- mode  in  2  00 LSB, 01 USB, 10 AM, 11 mute.
- gain_shift  in  2  left-shift gain applied before output scaling.
- out_valid  out  1  one-cycle strobe, output sample valid.
- out_data  out  WIDTH  demodulated sample, signed.
- out_clip  out  1  high with out_valid when saturation occurred on that sample.

Behaviour:
- Reset (synchronous, active-high): out_valid=0, out_data=0, out_clip=0. Reset also clears all pipeline valids, the mute counter and first_flag=1. Samples in flight are discarded, with no output for them.
- No backpressure. Any cycle may carry in_valid. Back-to-back samples are supported at full rate.
- Latency: exactly 3 clk from in_valid to out_valid. Valid and sideband bits travel with their sample.
- mode and gain_shift are sampled only when in_valid=1. Changes between valids are ignored.
- Stage 1: register a and b sign-extended to WIDTH+1.
  - LSB: r = a - b.
  - USB: r = a + b.
  - AM: register |a| and |b| as WIDTH+1 unsigned. |−2^(WIDTH-1)| = 2^(WIDTH-1) is exact.
  - mute: r = 0.
- Stage 2: AM computes r = max(|a|,|b|) + (min(|a|,|b|) >> 1), which is non-negative. SSB and mute pass r through. r is held at WIDTH+2 bits signed.
- Stage 3: g = min(gain_shift, MAX_GAIN). Compute v = (r <<< g) >>> 1, with the arithmetic shift rounding toward −inf.
  - Saturate v to [−2^(WIDTH-1), 2^(WIDTH-1)−1].
  - out_clip=1 iff the limit was applied.
  - With g=0, SSB and AM never clip.
- Mode-change mute: stage 3 compares the sample's mode with last_mode.
  - If they differ and first_flag=0: load mute_cnt=MUTE_SAMPLES.
  - While mute_cnt>0 on a valid output: out_data=0, out_clip=0, and mute_cnt decrements. The sample that triggered the load counts as the first muted output.
  - A new change while muting reloads mute_cnt to MUTE_SAMPLES.
  - On every valid output, last_mode is updated to the sample's mode.
  - The first valid output after reset sets last_mode, clears first_flag, and does not trigger a mute.
  - A change to mode 11 still loads the counter. Mode 11 output is always 0.
  - MUTE_SAMPLES=0: never mute.
- out_data and out_clip hold their last values when out_valid=0.

Test Plan:
- WIDTH=12, g=0, USB, a=100, b=50 -> out_data=75, 3 cycles later. LSB with the same inputs -> 25. LSB a=−3, b=0 -> −2.
- Extremes, g=0: LSB a=2047, b=−2048 -> 2047. LSB a=−2048, b=2047 -> −2048. out_clip=0 in both cases.
- USB a=1000, b=1000, gain_shift=2 -> out_data=2047, out_clip=1. Same inputs with a=b=−1000 -> −2048, out_clip=1.
- AM a=−800, b=400, g=0 -> 500. AM a=−2048, b=−2048 -> 1536.
- MUTE_SAMPLES=4: 10 USB samples then 10 LSB samples, continuous valids -> first LSB output plus the next 3 are 0, then normal LSB values. The first sample after reset (USB) is not muted.
- Assert reset for 1 cycle with 3 samples in flight -> no out_valid for those samples, outputs 0 next cycle. A new sample 3 cycles later is processed normally.
